// File: rtl/hdmi_row_fetch_pkg.sv
// Shared video timing defaults, game geometry and pixel types for the HDMI row fetch path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hdmi_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int GAME_W = 320;
    localparam int GAME_H = 240;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic [5:0] palette;
        logic [3:0] color;
    } rowram_entry_t;

    // Colour of each of the eight test-pattern bars, left to right.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_row_fetch_timing.sv
// Free-running 640x480 raster counters with raw (undelayed) sync, active and frame-start flags.
// Latency: flags are combinational from the counter registers.
// Backpressure: none; the pixel clock always advances the raster.
module video_timing_gen #(
    parameter int H_ACTIVE = hdmi_pkg::H_ACTIVE,
    parameter int H_FP     = hdmi_pkg::H_FP,
    parameter int H_SYNC   = hdmi_pkg::H_SYNC,
    parameter int H_BP     = hdmi_pkg::H_BP,
    parameter int V_ACTIVE = hdmi_pkg::V_ACTIVE,
    parameter int V_FP     = hdmi_pkg::V_FP,
    parameter int V_SYNC   = hdmi_pkg::V_SYNC,
    parameter int V_BP     = hdmi_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active,
    output logic       frame_start
);
    import hdmi_pkg::*;

    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] H_LST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_B  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_E  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] V_LST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_B  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_E  = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Raster position; reset parks on the last line so the first frame is preceded by one full line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= V_LST;
        end else if (hcnt == H_LST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LST) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Raw flags decoded straight from the counters.
    always_comb begin
        hsync_n     = !((hcnt >= HS_B) && (hcnt < HS_E));
        vsync_n     = !((vcnt >= VS_B) && (vcnt < VS_E));
        active      = (hcnt < H_ACT) && (vcnt < V_ACT);
        frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);
    end

endmodule

// File: rtl/hdmi_row_fetch.sv
// Display side of the PPU row RAM: raster timing, 2x2 pixel doubling, palette lookup, row-swap handshake.
// Latency: 3 clocks from raster counters to vid_*; HDMI_ROW_FETCH_TESTPAT_EN adds a colour-bar override input.
// Backpressure: none; the sink must accept one pixel per clock and the RAMs must answer with 1-cycle latency.
module hdmi_row_fetch #(
    parameter int H_ACTIVE = hdmi_pkg::H_ACTIVE,
    parameter int H_FP     = hdmi_pkg::H_FP,
    parameter int H_SYNC   = hdmi_pkg::H_SYNC,
    parameter int H_BP     = hdmi_pkg::H_BP,
    parameter int V_ACTIVE = hdmi_pkg::V_ACTIVE,
    parameter int V_FP     = hdmi_pkg::V_FP,
    parameter int V_SYNC   = hdmi_pkg::V_SYNC,
    parameter int V_BP     = hdmi_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef HDMI_ROW_FETCH_TESTPAT_EN
    input  logic        testpat_en,
`endif
    output logic [8:0]  hdmi_rowram_rdaddr,
    input  logic [9:0]  hdmi_rowram_rddata,
    output logic [8:0]  hdmi_palram_rdaddr,
    input  logic [63:0] hdmi_palram_rddata,
    output logic        rowram_swap,
    output logic [7:0]  next_row,
    output logic        frame_start,
    output logic [23:0] vid_rgb,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de
);
    import hdmi_pkg::*;

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SWP  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LACT = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] ROWS   = 10'(V_ACTIVE / 2);

    logic [9:0]    hcnt, vcnt;
    logic          hsync_raw, vsync_raw, active_raw, fs_raw;
    rowram_entry_t ent;
    logic [2:0]    de_sr, hs_sr, vs_sr, fs_sr;
    logic          half_q1, half_q2;
    logic          swap_due;
    logic [9:0]    row_odd, row_nxt;
    rgb_t          pal_rgb;
    logic          unused_bits;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hsync_n    (hsync_raw),
        .vsync_n    (vsync_raw),
        .active     (active_raw),
        .frame_start(fs_raw)
    );

    // Stage 0: each game column is shown on two consecutive pixel clocks.
    assign hdmi_rowram_rdaddr = (hcnt < H_ACT) ? hcnt[9:1] : 9'd0;
    assign ent                = rowram_entry_t'(hdmi_rowram_rddata);
    assign unused_bits        = ^{hdmi_palram_rddata[63:56], hdmi_palram_rddata[31:24]};

    // Stages 1-2: palette word address plus the even/odd half-select, and the 3-deep control delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdmi_palram_rdaddr <= '0;
            half_q1            <= 1'b0;
            half_q2            <= 1'b0;
            de_sr              <= '0;
            hs_sr              <= '1;
            vs_sr              <= '1;
            fs_sr              <= '0;
        end else begin
            hdmi_palram_rdaddr <= {ent.palette, ent.color[3:1]};
            half_q1            <= ent.color[0];
            half_q2            <= half_q1;
            de_sr              <= {de_sr[1:0], active_raw};
            hs_sr              <= {hs_sr[1:0], hsync_raw};
            vs_sr              <= {vs_sr[1:0], vsync_raw};
            fs_sr              <= {fs_sr[1:0], fs_raw};
        end
    end

    assign vid_de      = de_sr[2];
    assign vid_hsync   = hs_sr[2];
    assign vid_vsync   = vs_sr[2];
    assign frame_start = fs_sr[2];

    // Which row the PPU composes next: pre-frame line hands over row 1, each second copy of row r hands over r+2.
    always_comb begin
        swap_due = 1'b0;
        row_odd  = {1'b0, vcnt[9:1]} + 10'd2;
        row_nxt  = '0;
        if (vcnt == V_LST) begin
            swap_due = 1'b1;
            row_nxt  = 10'd1;
        end else if (vcnt[0] && (vcnt < V_LACT)) begin
            swap_due = 1'b1;
            row_nxt  = (row_odd >= ROWS) ? 10'd0 : row_odd;
        end
    end

    // Registered one clock early so the pulse and the new row both appear while hcnt == H_ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowram_swap <= 1'b0;
            next_row    <= '0;
        end else begin
            rowram_swap <= (hcnt == H_SWP) && swap_due;
            if ((hcnt == H_SWP) && swap_due) begin
                next_row <= row_nxt[7:0];
            end
        end
    end

    assign pal_rgb = half_q2 ? hdmi_palram_rddata[55:32] : hdmi_palram_rddata[23:0];

`ifdef HDMI_ROW_FETCH_TESTPAT_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic [2:0] bar_d1, bar_d2, bar_d3;
    logic [2:0] tp_sr;

    // Bar index and enable ride the same 3-clock delay as the palette path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_d1 <= '0;
            bar_d2 <= '0;
            bar_d3 <= '0;
            tp_sr  <= '0;
        end else begin
            bar_d1 <= 3'(hcnt / BAR_W);
            bar_d2 <= bar_d1;
            bar_d3 <= bar_d2;
            tp_sr  <= {tp_sr[1:0], testpat_en};
        end
    end

    // Output colour: blank outside the active area, bars override the palette when enabled.
    always_comb begin
        vid_rgb = '0;
        if (vid_de) begin
            vid_rgb = tp_sr[2] ? bar_color(bar_d3) : pal_rgb;
        end
    end
`else
    // Output colour: blank outside the active area.
    always_comb begin
        vid_rgb = '0;
        if (vid_de) begin
            vid_rgb = pal_rgb;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_row_fetch.sv
// Directed bench for hdmi_row_fetch with a shortened vertical raster (full 800-clock lines, 23 lines/frame).
// Latency: expects 3 clocks from raster counters to video outputs.
// Backpressure: none; RAM models answer every address one clock later.
module tb_hdmi_row_fetch;

    localparam int VA    = 16;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int VT    = VA + VF + VS + VB;
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  hdmi_rowram_rdaddr;
    logic [9:0]  hdmi_rowram_rddata = '0;
    logic [8:0]  hdmi_palram_rdaddr;
    logic [63:0] hdmi_palram_rddata = '0;
    logic        rowram_swap;
    logic [7:0]  next_row;
    logic        frame_start;
    logic [23:0] vid_rgb;
    logic        vid_hsync, vid_vsync, vid_de;
`ifdef HDMI_ROW_FETCH_TESTPAT_EN
    logic        testpat_en = 1'b0;
`endif

    logic [9:0]  rowram_word = 10'h053;
    int          n_chk = 0;
    int          n_err = 0;

    always #20 clk = ~clk;

    hdmi_row_fetch #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
`ifdef HDMI_ROW_FETCH_TESTPAT_EN
        .testpat_en        (testpat_en),
`endif
        .hdmi_rowram_rdaddr(hdmi_rowram_rdaddr),
        .hdmi_rowram_rddata(hdmi_rowram_rddata),
        .hdmi_palram_rdaddr(hdmi_palram_rdaddr),
        .hdmi_palram_rddata(hdmi_palram_rddata),
        .rowram_swap       (rowram_swap),
        .next_row          (next_row),
        .frame_start       (frame_start),
        .vid_rgb           (vid_rgb),
        .vid_hsync         (vid_hsync),
        .vid_vsync         (vid_vsync),
        .vid_de            (vid_de)
    );

    // Synchronous-read RAM models; only palette word 0x029 holds the colours under test.
    always @(posedge clk) begin
        hdmi_rowram_rddata <= rowram_word;
        hdmi_palram_rddata <= (hdmi_palram_rdaddr == 9'h029) ? {32'h00123456, 32'h00ABCDEF}
                                                             : 64'h00C0FFEE_00BADBAD;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_de"},     vid_de, 0);
        check({tag, "_rgb"},    vid_rgb, 0);
        check({tag, "_hsync"},  vid_hsync, 1);
        check({tag, "_vsync"},  vid_vsync, 1);
        check({tag, "_swap"},   rowram_swap, 0);
        check({tag, "_fs"},     frame_start, 0);
        check({tag, "_nrow"},   next_row, 0);
    endtask

    // From reset release: pre-frame swap at clock 640 (row 1), frame_start and first DE at clock 803.
    task automatic startup(input string tag);
        int   n = 0;
        int   sw_n = -1;
        logic [7:0] sw_row = '0;
        logic de_early = 1'b0;
        bit   got = 0;
        while (n < 2000 && !got) begin
            @(negedge clk);
            n++;
            if (rowram_swap && sw_n < 0) begin
                sw_n   = n;
                sw_row = next_row;
            end
            if (frame_start) got = 1;
            else if (vid_de) de_early = 1'b1;
        end
        check({tag, "_fs_latency"},  n, 803);
        check({tag, "_de_at_fs"},    vid_de, 1);
        check({tag, "_de_early"},    de_early, 0);
        check({tag, "_swap_clock"},  sw_n, 640);
        check({tag, "_swap_row"},    sw_row, 1);
    endtask

    // One full frame starting on a frame_start sample; word_next is loaded during vertical blanking.
    task automatic run_frame(input string tag, input logic [23:0] exp_rgb, input logic [9:0] word_next);
        int de_cnt = 0, rgb_bad = 0, blank_bad = 0, hs_run = 0, hs_runs = 0, hs_bad = 0;
        int vs_low = 0, ra_bad = 0, pa_bad = 0, sw_pos_bad = 0, fs_extra = 0, h, exp_ra;
        logic [7:0] rows[$];
        logic [7:0] exp_rows [8] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1};
        for (int i = 0; i < FRAME; i++) begin
            h = (i + 3) % HT;
            if (i == FRAME - 100) rowram_word = word_next;
            if (vid_de) begin
                de_cnt++;
                if (vid_rgb !== exp_rgb) rgb_bad++;
            end else if (vid_rgb !== 24'h0) blank_bad++;
            if (!vid_hsync) hs_run++;
            else if (hs_run != 0) begin
                hs_runs++;
                if (hs_run != 96) hs_bad++;
                hs_run = 0;
            end
            if (!vid_vsync) vs_low++;
            exp_ra = (h < 640) ? h / 2 : 0;
            if (hdmi_rowram_rdaddr !== 9'(exp_ra)) ra_bad++;
            if (hdmi_palram_rdaddr !== 9'h029) pa_bad++;
            if (rowram_swap) begin
                rows.push_back(next_row);
                if ((i % HT) != 637) sw_pos_bad++;
            end
            if (frame_start && i != 0) fs_extra++;
            @(negedge clk);
        end
        check({tag, "_frame_period"}, frame_start, 1);
        check({tag, "_fs_extra"},     fs_extra, 0);
        check({tag, "_de_count"},     de_cnt, 640 * VA);
        check({tag, "_rgb_bad"},      rgb_bad, 0);
        check({tag, "_blank_bad"},    blank_bad, 0);
        check({tag, "_hs_runs"},      hs_runs, VT);
        check({tag, "_hs_width"},     hs_bad, 0);
        check({tag, "_vs_low"},       vs_low, VS * HT);
        check({tag, "_rdaddr"},       ra_bad, 0);
        check({tag, "_paladdr"},      pa_bad, 0);
        check({tag, "_swap_count"},   rows.size(), 8);
        check({tag, "_swap_pos"},     sw_pos_bad, 0);
        for (int k = 0; k < 8 && k < rows.size(); k++)
            check($sformatf("%s_next_row%0d", tag, k), rows[k], exp_rows[k]);
    endtask

    initial begin
        int sw_in_rst;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        startup("start");
        run_frame("odd_half", 24'h123456, 10'h052);
        run_frame("even_half", 24'hABCDEF, 10'h052);

        // Mid-line reset at hcnt=300, vcnt=5 (we sit on a frame_start sample: hcnt=3, vcnt=0).
        repeat (5 * HT + 297) @(negedge clk);
        check("pre_rst_de", vid_de, 1);
        check("pre_rst_nrow", next_row, 3);
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        sw_in_rst = 0;
        repeat (5) begin
            @(negedge clk);
            if (rowram_swap) sw_in_rst++;
        end
        check("swap_in_rst", sw_in_rst, 0);
`ifdef HDMI_ROW_FETCH_TESTPAT_EN
        testpat_en = 1'b1;
`endif
        rst_n = 1'b1;
        startup("restart");

`ifdef HDMI_ROW_FETCH_TESTPAT_EN
        check("bar_px0", vid_rgb, 24'hFFFFFF);
        repeat (80) @(negedge clk);
        check("bar_px80", vid_rgb, 24'hFFFF00);
        repeat (559) @(negedge clk);
        check("bar_px639", vid_rgb, 24'h000000);
        check("bar_px639_de", vid_de, 1);
        repeat (158 + 103) @(negedge clk);
        check("bar_px100", vid_rgb, 24'hFFFF00);
        testpat_en = 1'b0;
        @(negedge clk);
        check("tp_off_d1", vid_rgb, 24'hFFFF00);
        @(negedge clk);
        check("tp_off_d2", vid_rgb, 24'hFFFF00);
        @(negedge clk);
        check("tp_off_d3", vid_rgb, 24'hABCDEF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hdmi_row_fetch.md
Name: hdmi_row_fetch

Overview:
- Consumer end of the PPU row-RAM/palette path: generates 640x480 video timing and reads the visible row RAM and the PPU-facing palette RAM.
- Each 320x240 game pixel is doubled in both axes; palette indices resolve to 24-bit RGB.
- Issues the rowram_swap pulse and the next-row request that tell ppu_logic which game row to compose next.
- Sits between ppu_logic and the HDMI serializer/TX.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- hdmi_rowram_rdaddr  out  9  game column 0..319 for the visible row RAM
- hdmi_rowram_rddata  in  10  {palette[5:0], color[3:0]}; 1-cycle read latency
- hdmi_palram_rdaddr  out  9  palette word address
- hdmi_palram_rddata  in  64  two colours per word: [31:0] even, [63:32] odd; RGB in [23:0]; 1-cycle latency
- rowram_swap  out  1  one-cycle pulse: exchange display/compose row RAMs
- next_row  out  8  game row (0..239) ppu_logic composes after the swap
- frame_start  out  1  one-cycle pulse aligned with the first active pixel of the frame
- vid_rgb  out  24  pixel colour, 0 outside the active area
- vid_hsync  out  1  active-low
- vid_vsync  out  1  active-low
- vid_de  out  1  data enable

Behaviour:
- Counters:
  - hcnt 0..H_TOTAL-1 (800); wraps to 0 and advances vcnt.
  - vcnt 0..V_TOTAL-1 (525); wraps to 0.
  - Active area: hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- Stage 0 (combinational from counters):
  - hdmi_rowram_rdaddr = hcnt[9:1] when hcnt<H_ACTIVE, else 0.
  - Each address is held for 2 cycles (horizontal doubling).
- Stage 1: hdmi_palram_rdaddr = registered rowram_rddata[9:1]; register rowram_rddata[0] as the half-select bit.
- Stage 2: select palram half by the registered bit; vid_rgb = selected[23:0] if the delayed active flag is set, else 0.
- Total latency: counters to vid_* outputs = 3 cycles. hsync, vsync, de and frame_start go through the same 3-stage delay.
- Sync timing:
  - hsync low when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync low on the equivalent vertical range.
- Swap rule: rowram_swap pulses for 1 cycle at hcnt==H_ACTIVE when either:
  - vcnt is odd and vcnt < V_ACTIVE-1 (the second display of a game row has finished), or
  - vcnt == V_TOTAL-1 (pre-frame swap, so composed row 0 becomes visible).
- Swap boundary case: no swap at vcnt==V_ACTIVE-1 (row 239). The next swap is the pre-frame one.
- next_row:
  - Updated in the same cycle as the swap, to the row the PPU must compose next.
  - At vcnt==V_TOTAL-1 it becomes 1.
  - At odd vcnt it becomes (vcnt+1)/2+1, saturating: once the value would be 240, it holds 0 (row 0 for the following frame).
  - Reset value 0, so ppu_logic composes row 0 during the first blanking.
- Reset (async assert, sync deassert assumed upstream):
  - hcnt=0, vcnt=V_TOTAL-1 (first frame starts after a pre-frame line).
  - All pipeline registers cleared; vid_rgb=0, vid_de=0, vid_hsync=1, vid_vsync=1, rowram_swap=0, frame_start=0, next_row=0.
  - Reset mid-line discards in-flight pixels with no partial swap.
- frame_start is generated at hcnt==0 && vcnt==0 and delayed 3 cycles.

Optional Feature:
- Macro: HDMI_ROW_FETCH_TESTPAT_EN
- Defined:
  - Adds input testpat_en (1 bit).
  - When high, stage 2 outputs 8 vertical colour bars of 80 px each in this order: white, yellow, cyan, green, magenta, red, blue, black (FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000).
  - Palette data is ignored; timing, swap and latency are unchanged.
- Undefined: no port and no logic; output is always palette-derived.

Decomposition:
- Package hdmi_pkg:
  - Timing constants (defaults above, H_TOTAL, V_TOTAL).
  - Game resolution constants GAME_W=320, GAME_H=240.
  - typedef rgb_t (24 bit).
  - typedef rowram_entry_t struct {palette[5:0], color[3:0]}.
- Sub-module video_timing_gen: counters plus raw hsync/vsync/active/frame_start. The fetch pipeline and swap logic stay in hdmi_row_fetch.

Test Plan:
- Reset then free-run one frame:
  - First vid_de rise exactly 3 cycles after hcnt=0,vcnt=0.
  - hsync low for 96 clocks per line; vsync low for 2 lines; 800x525 clocks per frame.
- Rowram model returns {pal=6'h05, col=4'h3}, so palram addr is 9'h029 with odd half selected; model word {32'h00123456, 32'h00ABCDEF}:
  - vid_rgb=24'h123456 on every active pixel.
- Rowram data = column index: each rdaddr is held exactly 2 clocks; addresses run 0..319 per line.
- Count swaps per frame:
  - Exactly 240 pulses: one at vcnt=V_TOTAL-1 (next_row becomes 1) and 239 at odd lines 1..477.
  - next_row sequence 1,2,...,239,0.
- Assert rst_n low at hcnt=300, vcnt=100 for 5 cycles:
  - Outputs at reset values immediately (async).
  - No rowram_swap pulse during or within 3 cycles after reset.
- With HDMI_ROW_FETCH_TESTPAT_EN defined and testpat_en=1:
  - Pixel 0 = FFFFFF, pixel 80 = FFFF00, pixel 639 = 000000.
  - Deasserting testpat_en returns palette output with the same 3-cycle latency.
